// File: rtl/mac_pkg.sv
// Shared types and constants for the int8 MAC accumulate/requantise datapath.
package mac_pkg;

  localparam int unsigned ACC_W_DEF   = 32;
  localparam int unsigned LEN_W_DEF   = 16;
  localparam int unsigned SHIFT_W_DEF = 5;

  typedef enum logic [1:0] {IDLE, ACC, POST, OUT} state_t;

  typedef logic signed [ACC_W_DEF-1:0] psum_t;
  typedef logic signed [ACC_W_DEF-1:0] acc_t;

  localparam acc_t ACC_MAX  = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam acc_t ACC_MIN  = {1'b1, {(ACC_W_DEF-1){1'b0}}};
  localparam int   INT8_MAX = 127;
  localparam int   INT8_MIN = -128;

endpackage

// File: rtl/mac_requant.sv
// Combinational requantisation: optional ReLU, arithmetic right shift, optional int8 clamp.
module mac_requant
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned SHIFT_W = SHIFT_W_DEF
) (
  input  logic signed [ACC_W-1:0]   acc_i,
  input  logic        [SHIFT_W-1:0] shift_i,
  input  logic                      relu_i,
  input  logic                      sat8_i,
  output logic signed [ACC_W-1:0]   res_o
);

  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(INT8_MAX);
  localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(INT8_MIN);

  logic signed [ACC_W-1:0] rect;
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    rect    = (relu_i && acc_i[ACC_W-1]) ? '0 : acc_i;
    shifted = rect >>> shift_i;
    res_o   = shifted;
    if (sat8_i) begin
      if (shifted > Q_MAX) begin
        res_o = Q_MAX;
      end else if (shifted < Q_MIN) begin
        res_o = Q_MIN;
      end
    end
  end

endmodule

// File: rtl/mac_acc_requant.sv
// Accumulates a programmed number of partial dot-products on top of a bias with
// saturation, then requantises and hands one result out over valid/ready.
module mac_acc_requant
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned SHIFT_W = SHIFT_W_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic        [LEN_W-1:0]   len_i,
  input  logic signed [ACC_W-1:0]   bias_i,
  input  logic        [SHIFT_W-1:0] shift_i,
  input  logic                      relu_i,
  input  logic                      sat8_i,
  input  logic                      psum_valid_i,
  output logic                      psum_ready_o,
  input  logic signed [ACC_W-1:0]   psum_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic signed [ACC_W-1:0]   res_o,
  output logic                      ovf_o,
  output logic                      busy_o
);

  localparam logic signed [ACC_W-1:0] A_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] A_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                  state, state_nx;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        count;
  logic [SHIFT_W-1:0]      shift_q;
  logic                    relu_q;
  logic                    sat8_q;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] requant;
  logic                    acc_ovf;
  logic                    start_fire;
  logic                    psum_hs;
  logic                    last_beat;

  assign psum_ready_o = (state == ACC);
  assign res_valid_o  = (state == OUT);
  assign busy_o       = (state != IDLE);
  assign start_fire   = (state == IDLE) && start_i;
  assign psum_hs      = psum_ready_o && psum_valid_i;
  // count only reaches len-1, so the maximum len never wraps the counter
  assign last_beat    = psum_hs && (count == len_q - LEN_W'(1));

  always_comb begin
    acc_sum  = acc + psum_i;
    acc_ovf  = (acc[ACC_W-1] == psum_i[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);
    acc_next = acc_sum;
    if (acc_ovf) begin
      acc_next = acc[ACC_W-1] ? A_MIN : A_MAX;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start_i) state_nx = (len_i != '0) ? ACC : POST;
      ACC:  if (last_beat) state_nx = POST;
      POST: state_nx = OUT;
      OUT:  if (res_ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  mac_requant #(
    .ACC_W   (ACC_W),
    .SHIFT_W (SHIFT_W)
  ) u_requant (
    .acc_i   (acc),
    .shift_i (shift_q),
    .relu_i  (relu_q),
    .sat8_i  (sat8_q),
    .res_o   (requant)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      len_q   <= '0;
      count   <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      sat8_q  <= 1'b0;
      acc     <= '0;
      res_o   <= '0;
      ovf_o   <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_fire) begin
        len_q   <= len_i;
        shift_q <= shift_i;
        relu_q  <= relu_i;
        sat8_q  <= sat8_i;
        acc     <= bias_i;
        count   <= '0;
        ovf_o   <= 1'b0;
      end
      if (psum_hs) begin
        acc   <= acc_next;
        count <= count + LEN_W'(1);
        if (acc_ovf) ovf_o <= 1'b1;
      end
      if (state == POST) begin
        res_o <= requant;
      end
    end
  end

endmodule
